code_lock_ctrl: RTL and testbench

//  Parametrised lock controller, next generation of the keypad lock decision logic.

---
 rtl/code_lock_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// Keypad code lock controller: N-digit entry, wrong-attempt lockout, timed relock, in-field code change.
// Optional macro IDLE_TIMEOUT_EN adds an idle timeout that discards a stale partial entry.
module code_lock_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_WRONG      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int OPEN_CYCLES    = 500,
    parameter int IDLE_CYCLES    = 2000,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 key_valid,
    input  logic [3:0]                           key_code,
    input  logic                                 set,
    output logic                                 open,
    output logic                                 lock,
    output logic                                 lockout,
    output logic                                 change,
    output logic                                 save_light,
    output logic [NUM_DIGITS*DIGIT_W-1:0]        data,
    output logic [$clog2(MAX_WRONG+1)-1:0]       count_wrong
);

    localparam int DW   = NUM_DIGITS * DIGIT_W;
    localparam int CW   = $clog2(NUM_DIGITS + 1);
    localparam int WW   = $clog2(MAX_WRONG + 1);
    localparam int LW   = $clog2(LOCKOUT_CYCLES + 1);
    localparam int OW   = $clog2(OPEN_CYCLES + 1);

    localparam logic [1:0] ST_LOCKED  = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_SET_NEW = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    logic [1:0]    state_r, state_nxt_s;
    logic [DW-1:0] data_r, data_nxt_s, code_r, code_nxt_s;
    logic [CW-1:0] dcnt_r, dcnt_nxt_s;
    logic [WW-1:0] wrong_r, wrong_nxt_s, wrong_inc_s;
    logic [LW-1:0] lo_cnt_r, lo_cnt_nxt_s;
    logic [OW-1:0] op_cnt_r, op_cnt_nxt_s;
    logic          save_nxt_s;
    logic          is_digit_s, is_enter_s, is_clear_s, is_change_s, is_lock_s;
    logic [DW-1:0] entry_data_s;
    logic [CW-1:0] entry_dcnt_s;
    logic          full_s, match_s, idle_fire_s;

    assign is_digit_s  = key_valid && (key_code <= 4'd9);
    assign is_enter_s  = key_valid && (key_code == 4'hA);
    assign is_clear_s  = key_valid && (key_code == 4'hB);
    assign is_change_s = key_valid && (key_code == 4'hC);
    assign is_lock_s   = key_valid && (key_code == 4'hD);
    assign full_s      = (dcnt_r == CW'(NUM_DIGITS));
    assign match_s     = full_s && (data_r == code_r);
    assign wrong_inc_s = (wrong_r == WW'(MAX_WRONG)) ? wrong_r : wrong_r + WW'(1);

`ifdef IDLE_TIMEOUT_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_cnt_r;

    assign idle_fire_s = (state_r == ST_LOCKED || state_r == ST_SET_NEW) && (dcnt_r != CW'(0))
                         && !key_valid && (idle_cnt_r == IW'(IDLE_CYCLES - 1));

    // Idle timer runs only while a partial entry is pending and no key arrives
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else if (!(state_r == ST_LOCKED || state_r == ST_SET_NEW) || dcnt_r == CW'(0)
                     || key_valid || idle_fire_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + IW'(1);
        end
    end
`else
    assign idle_fire_s = 1'b0;
`endif

    // Shared digit-entry datapath; digits beyond NUM_DIGITS are dropped without shifting
    always_comb begin
        entry_data_s = data_r;
        entry_dcnt_s = dcnt_r;
        if (is_digit_s && !full_s) begin
            entry_data_s = (data_r << DIGIT_W) | DW'(key_code);
            entry_dcnt_s = dcnt_r + CW'(1);
        end else if (is_clear_s || idle_fire_s) begin
            entry_data_s = '0;
            entry_dcnt_s = '0;
        end else begin
            entry_data_s = data_r;
            entry_dcnt_s = dcnt_r;
        end
    end

    // Next-state logic; timers read zero outside their own state so each entry starts fresh
    always_comb begin
        state_nxt_s  = state_r;
        data_nxt_s   = data_r;
        dcnt_nxt_s   = dcnt_r;
        code_nxt_s   = code_r;
        wrong_nxt_s  = wrong_r;
        lo_cnt_nxt_s = '0;
        op_cnt_nxt_s = '0;
        save_nxt_s   = 1'b0;
        case (state_r)
            ST_LOCKED: begin
                if (is_enter_s) begin
                    data_nxt_s = '0;
                    dcnt_nxt_s = '0;
                    if (match_s) begin
                        state_nxt_s = ST_OPEN;
                        wrong_nxt_s = '0;
                    end else if (wrong_inc_s == WW'(MAX_WRONG)) begin
                        state_nxt_s = ST_LOCKOUT;
                        wrong_nxt_s = wrong_inc_s;
                    end else begin
                        wrong_nxt_s = wrong_inc_s;
                    end
                end else begin
                    data_nxt_s = entry_data_s;
                    dcnt_nxt_s = entry_dcnt_s;
                end
            end
            ST_OPEN: begin
                if (is_lock_s) begin
                    state_nxt_s = ST_LOCKED;
                end else if (is_change_s || set) begin
                    state_nxt_s = ST_SET_NEW;
                end else if (key_valid) begin
                    op_cnt_nxt_s = '0;
                end else if (op_cnt_r == OW'(OPEN_CYCLES - 1)) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    op_cnt_nxt_s = op_cnt_r + OW'(1);
                end
            end
            ST_SET_NEW: begin
                if (is_enter_s || is_lock_s || idle_fire_s) begin
                    state_nxt_s = is_lock_s ? ST_LOCKED : ST_OPEN;
                    data_nxt_s  = '0;
                    dcnt_nxt_s  = '0;
                    if (is_enter_s && full_s) begin
                        code_nxt_s = data_r;
                        save_nxt_s = 1'b1;
                    end else begin
                        code_nxt_s = code_r;
                    end
                end else begin
                    data_nxt_s = entry_data_s;
                    dcnt_nxt_s = entry_dcnt_s;
                end
            end
            ST_LOCKOUT: begin
                if (lo_cnt_r == LW'(LOCKOUT_CYCLES - 1)) begin
                    state_nxt_s = ST_LOCKED;
                    wrong_nxt_s = '0;
                end else begin
                    lo_cnt_nxt_s = lo_cnt_r + LW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_LOCKED;
                data_nxt_s  = '0;
                dcnt_nxt_s  = '0;
            end
        endcase
    end

    // State, datapath and registered output flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_LOCKED;
            data_r      <= '0;
            dcnt_r      <= '0;
            code_r      <= DEFAULT_CODE;
            wrong_r     <= '0;
            lo_cnt_r    <= '0;
            op_cnt_r    <= '0;
            open        <= 1'b0;
            lock        <= 1'b1;
            lockout     <= 1'b0;
            change      <= 1'b0;
            save_light  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            data_r      <= data_nxt_s;
            dcnt_r      <= dcnt_nxt_s;
            code_r      <= code_nxt_s;
            wrong_r     <= wrong_nxt_s;
            lo_cnt_r    <= lo_cnt_nxt_s;
            op_cnt_r    <= op_cnt_nxt_s;
            open        <= (state_nxt_s == ST_OPEN);
            lock        <= (state_nxt_s == ST_LOCKED) || (state_nxt_s == ST_LOCKOUT);
            lockout     <= (state_nxt_s == ST_LOCKOUT);
            change      <= (state_nxt_s == ST_SET_NEW);
            save_light  <= save_nxt_s;
        end
    end

    assign data        = data_r;
    assign count_wrong = wrong_r;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed scoreboard bench for code_lock_ctrl (OPEN=16, LOCKOUT=32, IDLE=24 cycles).
module tb_code_lock_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        set = 1'b0;
    logic        open, lock, lockout, change, save_light;
    logic [15:0] data;
    logic [1:0]  count_wrong;

    int tests = 0;
    int failed = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb_q[$];

    localparam int S_OPEN = 0, S_LOCK = 1, S_LOCKOUT = 2, S_CHANGE = 3, S_SAVE = 4, S_DATA = 5, S_CW = 6;

    code_lock_ctrl #(
        .OPEN_CYCLES(16), .LOCKOUT_CYCLES(32), .IDLE_CYCLES(24)
    ) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code), .set(set),
        .open(open), .lock(lock), .lockout(lockout), .change(change), .save_light(save_light),
        .data(data), .count_wrong(count_wrong)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_OPEN:    return {31'd0, open};
            S_LOCK:    return {31'd0, lock};
            S_LOCKOUT: return {31'd0, lockout};
            S_CHANGE:  return {31'd0, change};
            S_SAVE:    return {31'd0, save_light};
            S_DATA:    return {16'd0, data};
            S_CW:      return {30'd0, count_wrong};
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic exp_push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic exp_flags(input string tag, input logic o, input logic l, input logic lo, input logic c);
        exp_push({tag, ".open"}, S_OPEN, {31'd0, o});
        exp_push({tag, ".lock"}, S_LOCK, {31'd0, l});
        exp_push({tag, ".lockout"}, S_LOCKOUT, {31'd0, lo});
        exp_push({tag, ".change"}, S_CHANGE, {31'd0, c});
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [31:0] o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.sel);
            tests++;
            assert (o === e.val) else begin
                failed++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clock);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) begin
            press(c[i*4 +: 4]);
        end
        press(4'hA);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] partial;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_flags("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        exp_push("reset.save", S_SAVE, 32'd0);
        exp_push("reset.data", S_DATA, 32'd0);
        exp_push("reset.cw", S_CW, 32'd0);
        check_sb();

        // 1: correct code opens, buffer builds newest digit in LSBs
        press(4'h1); exp_push("t1.d1", S_DATA, 32'h0001); check_sb();
        press(4'h2); exp_push("t1.d2", S_DATA, 32'h0012); check_sb();
        press(4'h3); exp_push("t1.d3", S_DATA, 32'h0123); check_sb();
        press(4'h4); exp_push("t1.d4", S_DATA, 32'h1234); check_sb();
        press(4'hA);
        exp_flags("t1.open", 1'b1, 1'b0, 1'b0, 1'b0);
        exp_push("t1.cw", S_CW, 32'd0);
        exp_push("t1.clr", S_DATA, 32'd0);
        check_sb();

        // 4: auto-relock after 16 idle cycles, and a key restarts the timer
        idle(15); exp_push("t4.open15", S_OPEN, 32'd1); check_sb();
        idle(1);  exp_flags("t4.relock", 1'b0, 1'b1, 1'b0, 1'b0); check_sb();
        press_code(16'h1234); exp_push("t4.reopen", S_OPEN, 32'd1); check_sb();
        idle(14);
        press(4'h5); exp_push("t4.key15", S_OPEN, 32'd1); check_sb();
        idle(1);  exp_push("t4.open16", S_OPEN, 32'd1); check_sb();
        idle(14); exp_push("t4.open30", S_OPEN, 32'd1); check_sb();
        idle(1);  exp_flags("t4.relock2", 1'b0, 1'b1, 1'b0, 1'b0); check_sb();

        // 2: three mismatches lock out; keys ignored; lockout lasts 32 cycles
        press_code(16'h1111); exp_push("t2.cw1", S_CW, 32'd1); exp_push("t2.lock1", S_LOCK, 32'd1); check_sb();
        press_code(16'h1111); exp_push("t2.cw2", S_CW, 32'd2); check_sb();
        press_code(16'h1111);
        exp_flags("t2.lockout", 1'b0, 1'b1, 1'b1, 1'b0);
        exp_push("t2.cw3", S_CW, 32'd3);
        check_sb();
        press_code(16'h1234);
        exp_flags("t2.ignored", 1'b0, 1'b1, 1'b1, 1'b0);
        exp_push("t2.ign_data", S_DATA, 32'd0);
        check_sb();
        idle(26); exp_push("t2.lo31", S_LOCKOUT, 32'd1); check_sb();
        idle(1);
        exp_flags("t2.release", 1'b0, 1'b1, 1'b0, 1'b0);
        exp_push("t2.cw_clr", S_CW, 32'd0);
        check_sb();
        press_code(16'h1234); exp_push("t2.open", S_OPEN, 32'd1); check_sb();

        // 3: change code to 5678
        press(4'hC); exp_flags("t3.setnew", 1'b0, 1'b0, 1'b0, 1'b1); check_sb();
        press(4'h5); press(4'h6); press(4'h7); press(4'h8);
        exp_push("t3.entry", S_DATA, 32'h5678); exp_push("t3.chg", S_CHANGE, 32'd1); check_sb();
        press(4'hA);
        exp_flags("t3.saved", 1'b1, 1'b0, 1'b0, 1'b0);
        exp_push("t3.save1", S_SAVE, 32'd1);
        check_sb();
        idle(1); exp_push("t3.save0", S_SAVE, 32'd0); check_sb();
        press(4'hD); exp_flags("t3.lockD", 1'b0, 1'b1, 1'b0, 1'b0); check_sb();
        press_code(16'h1234); exp_push("t3.oldcode", S_CW, 32'd1); exp_push("t3.oldlock", S_LOCK, 32'd1); check_sb();
        press_code(16'h5678); exp_push("t3.newcode", S_OPEN, 32'd1); exp_push("t3.cw0", S_CW, 32'd0); check_sb();

        // set level enters SET_NEW and re-enters after a short ENTER
        @(negedge clock); set = 1'b1;
        @(posedge clock); #1;
        exp_push("set.enter", S_CHANGE, 32'd1); check_sb();
        press(4'hA);
        exp_flags("set.short", 1'b1, 1'b0, 1'b0, 1'b0);
        exp_push("set.nosave", S_SAVE, 32'd0);
        check_sb();
        idle(1); exp_push("set.reenter", S_CHANGE, 32'd1); check_sb();
        @(negedge clock); set = 1'b0;
        press(4'hD); exp_flags("set.lockD", 1'b0, 1'b1, 1'b0, 1'b0); check_sb();

        // 5: fifth digit dropped, CLEAR, reset mid-lockout restores default code
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        exp_push("t5.full", S_DATA, 32'h1234); check_sb();
        press(4'hB); exp_push("t5.clear", S_DATA, 32'd0); check_sb();
        press_code(16'h1111); press_code(16'h1111); press_code(16'h1111);
        exp_push("t5.lockout", S_LOCKOUT, 32'd1); check_sb();
        idle(5);
        @(negedge clock); reset = 1'b1; #1;
        exp_flags("t5.rst", 1'b0, 1'b1, 1'b0, 1'b0);
        exp_push("t5.rst_cw", S_CW, 32'd0);
        check_sb();
        @(posedge clock);
        @(negedge clock); reset = 1'b0;
        press_code(16'h1234); exp_push("t5.default", S_OPEN, 32'd1); check_sb();
        press(4'hD); exp_push("t5.lockD", S_LOCK, 32'd1); check_sb();

        // 6: partial entry under idle
        press(4'h1); press(4'h2);
        idle(23); exp_push("t6.held23", S_DATA, 32'h0012); check_sb();
        idle(1);
`ifdef IDLE_TIMEOUT_EN
        partial = 16'h0000;
`else
        partial = 16'h0012;
`endif
        exp_push("t6.idle24", S_DATA, {16'd0, partial});
        exp_push("t6.lock", S_LOCK, 32'd1);
        check_sb();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
